// File: rtl/enc_gen.sv
// Quadrature encoder generator: accumulates signed step requests and replays
// each unit as a full-detent Gray sequence on enc_o with a programmable phase dwell.
module enc_gen #(
  parameter int CNT_W  = 4,
  parameter int PEND_W = 8,
  parameter int PH_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic signed [CNT_W-1:0]  step_i,
  input  logic                     clr_i,
  input  logic        [PH_W-1:0]   per_i,
  output logic        [1:0]        enc_o,
  output logic signed [PEND_W-1:0] pend_o,
  output logic                     busy_o,
  output logic                     sat_o
);

  typedef enum logic [1:0] {IDLE, MOVE, REST} state_t;

  localparam int SUM_W = PEND_W + 2;
  localparam logic signed [SUM_W-1:0] PMAX = {3'b000, {(PEND_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] PMIN = {3'b111, {(PEND_W-1){1'b0}}};

  state_t                    state_q, state_d;
  logic        [1:0]         ph_q, ph_d;
  logic                      dir_q, dir_d;      // 1 = CCW
  logic        [PH_W-1:0]    per_q, per_d;
  logic        [PH_W-1:0]    tmr_q, tmr_d;
  logic signed [PEND_W-1:0]  pend_q, pend_d;
  logic        [1:0]         enc_q, enc_d;
  logic                      busy_q, busy_d;
  logic                      sat_q, sat_d;
  logic signed [1:0]         take;
  logic signed [SUM_W-1:0]   pend_x, take_x, step_x, sum;
  logic        [1:0]         cw_code;

  // Detent sequencer.
  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    dir_d   = dir_q;
    per_d   = per_q;
    tmr_d   = tmr_q;
    take    = '0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          take    = pend_q[PEND_W-1] ? -2'sd1 : 2'sd1;
          dir_d   = pend_q[PEND_W-1];
          per_d   = per_i;
          tmr_d   = per_i;
          ph_d    = 2'd1;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          tmr_d = per_q;
          if (ph_q != 2'd3) ph_d = ph_q + 2'd1;
          else              state_d = REST;
        end
      end
      REST: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating accumulator, computed two bits wider so overflow is visible.
  always_comb begin
    pend_x = pend_q;
    take_x = take;
    step_x = '0;
    if (wr_i) step_x = step_i;
    sum    = pend_x - take_x + step_x;
    pend_d = sum[PEND_W-1:0];
    sat_d  = 1'b0;
    if (clr_i) begin
      pend_d = '0;
    end else if (sum > PMAX) begin
      pend_d = PMAX[PEND_W-1:0];
      sat_d  = 1'b1;
    end else if (sum < PMIN) begin
      pend_d = PMIN[PEND_W-1:0];
      sat_d  = 1'b1;
    end
  end

  // Outputs are registered from next-state; CCW phases are CW with the bits swapped.
  always_comb begin
    unique case (ph_d)
      2'd1:    cw_code = 2'b10;
      2'd2:    cw_code = 2'b00;
      default: cw_code = 2'b01;
    endcase
    enc_d = 2'b11;
    if (state_d == MOVE) enc_d = dir_d ? {cw_code[0], cw_code[1]} : cw_code;
    busy_d = (state_d != IDLE) || (pend_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments; the reset here is
  // synchronous, so rst_i only takes effect on a clk_i edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ph_q    <= '0;
      dir_q   <= 1'b0;
      per_q   <= '0;
      tmr_q   <= '0;
      pend_q  <= '0;
      enc_q   <= 2'b11;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      dir_q   <= dir_d;
      per_q   <= per_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      enc_q   <= enc_d;
      busy_q  <= busy_d;
      sat_q   <= sat_d;
    end
  end

  assign enc_o  = enc_q;
  assign pend_o = pend_q;
  assign busy_o = busy_q;
  assign sat_o  = sat_q;

endmodule

// File: tb/tb_enc_gen.sv
// Self-checking bench for enc_gen: directed scenarios plus random traffic, all
// compared every cycle against an elapsed-time reference model and a loopback decoder.
module tb_enc_gen;
  localparam int CNT_W  = 4;
  localparam int PEND_W = 8;
  localparam int PH_W   = 16;
  localparam int PMAX   = 2 ** (PEND_W - 1) - 1;
  localparam int PMIN   = -(2 ** (PEND_W - 1));

  logic                     clk = 1'b0;
  logic                     rst, wr, clr;
  logic signed [CNT_W-1:0]  step;
  logic        [PH_W-1:0]   per;
  logic        [1:0]        enc_o;
  logic signed [PEND_W-1:0] pend_o;
  logic                     busy_o, sat_o;

  enc_gen #(.CNT_W(CNT_W), .PEND_W(PEND_W), .PH_W(PH_W)) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .step_i(step), .clr_i(clr), .per_i(per),
    .enc_o(enc_o), .pend_o(pend_o), .busy_o(busy_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending count plus edges elapsed since the current detent started.
  int m_pend = 0;
  int m_j    = -1;
  int m_dir  = 1;
  int m_per  = 0;
  int e_sat  = 0;
  int cw_t[3]  = '{2, 0, 1};
  int ccw_t[3] = '{1, 0, 2};

  // Loopback decoder state.
  logic [1:0] prev_enc = 2'b11;
  int acc = 0;
  int dec_cnt = 0;

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pos(logic [1:0] e);
    case (e)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge();
    int tk = 0;
    int s;
    if (rst) begin
      m_pend = 0; m_j = -1; e_sat = 0;
      return;
    end
    if (m_j < 0 && m_pend != 0) tk = (m_pend > 0) ? 1 : -1;
    s = m_pend - tk + (wr ? int'(step) : 0);
    if (clr) begin
      m_pend = 0; e_sat = 0;
    end else begin
      e_sat  = (s > PMAX || s < PMIN) ? 1 : 0;
      m_pend = (s > PMAX) ? PMAX : (s < PMIN) ? PMIN : s;
    end
    if (tk != 0) begin
      m_j = 0; m_dir = tk; m_per = int'(per);
    end else if (m_j >= 0) begin
      m_j++;
      if (m_j == 4 * (m_per + 1)) m_j = -1;
    end
  endtask

  task automatic tick();
    int e_enc, idx, d;
    logic was_rst;
    @(posedge clk);
    was_rst = rst;
    model_edge();
    #1;
    if (m_j < 0) e_enc = 3;
    else begin
      idx   = m_j / (m_per + 1);
      e_enc = (idx == 3) ? 3 : (m_dir > 0 ? cw_t[idx] : ccw_t[idx]);
    end
    check("enc", enc_o, e_enc);
    check("pend", pend_o, m_pend);
    check("busy", busy_o, (m_j >= 0 || m_pend != 0) ? 1 : 0);
    check("sat", sat_o, e_sat);
    if (was_rst) begin
      acc = 0; prev_enc = enc_o;
    end else if (enc_o != prev_enc) begin
      check("gray_adj", $countones(enc_o ^ prev_enc), 1);
      d = (pos(enc_o) - pos(prev_enc) + 4) % 4;
      acc += (d == 1) ? 1 : (d == 3) ? -1 : 0;
      prev_enc = enc_o;
      if (enc_o == 2'b11) begin
        if (acc == 4) dec_cnt++;
        else if (acc == -4) dec_cnt--;
        acc = 0;
      end
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy_o, 0);
  endtask

  task automatic write(int s);
    wr = 1'b1; step = CNT_W'(s);
    tick();
    wr = 1'b0; step = '0;
  endtask

  initial begin
    int exp_enc;
    int ccw_seq[10] = '{1, 0, 2, 3, 3, 1, 0, 2, 3, 3};
    int nsat, nmove, n;

    rst = 1'b1; wr = 1'b0; clr = 1'b0; step = '0; per = '0;
    tick();
    check("reset_enc", enc_o, 3);
    check("reset_pend", pend_o, 0);
    check("reset_busy", busy_o, 0);
    rst = 1'b0;
    tick();

    // Single CW detent, per = 2.
    per = 16'd2;
    write(1);
    check("cw_pend_t1", pend_o, 1);
    for (int k = 2; k <= 14; k++) begin
      tick();
      exp_enc = (k <= 4) ? 2 : (k <= 7) ? 0 : (k <= 10) ? 1 : 3;
      check("cw_enc", enc_o, exp_enc);
      if (k == 2)  check("cw_pend_t2", pend_o, 0);
      if (k == 13) check("cw_busy_t13", busy_o, 1);
      if (k == 14) check("cw_busy_t14", busy_o, 0);
    end

    // Back-to-back CCW, per = 0.
    per = 16'd0;
    write(-2);
    check("ccw_pend_t1", pend_o, -2);
    for (int k = 2; k <= 11; k++) begin
      tick();
      check("ccw_enc", enc_o, ccw_seq[k-2]);
      check("ccw_pend", pend_o, (k <= 6) ? -1 : 0);
    end
    check("ccw_busy_end", busy_o, 0);

    // (a) write in the IDLE take cycle.
    write(3);
    write(-1);
    check("simul_a_pend", pend_o, 1);
    wait_idle(100);

    // (b) clear with write during MOVE: current detent finishes, nothing follows.
    write(3);
    tick();
    clr = 1'b1; wr = 1'b1; step = CNT_W'(5);
    nmove = 0;
    tick();
    clr = 1'b0; wr = 1'b0; step = '0;
    check("simul_b_pend", pend_o, 0);
    if (enc_o != 2'b11) nmove++;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (enc_o != 2'b11) nmove++;
    end
    check("simul_b_moves", nmove, 2);
    check("simul_b_busy", busy_o, 0);

    // Loopback through the decoder.
    per = 16'd1;
    dec_cnt = 0;
    write(5);
    wait_idle(200);
    check("loop_plus5", dec_cnt, 5);
    dec_cnt = 0;
    write(-3);
    wait_idle(200);
    check("loop_minus3", dec_cnt, -3);

    // Saturation: one take on the second write, clamping on writes 19 and 20.
    per = 16'hFFFF;
    nsat = 0;
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; step = CNT_W'(7);
      tick();
      if (sat_o) nsat++;
      check("sat_nowrap", (pend_o < 0) ? 1 : 0, 0);
    end
    wr = 1'b0; step = '0;
    tick();
    if (sat_o) nsat++;
    check("sat_pend", pend_o, PMAX);
    check("sat_pulses", nsat, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset mid-MOVE with enc = 00 and pend = 3.
    per = 16'd1;
    write(4);
    n = 0;
    while (enc_o !== 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("rst_pre_enc", enc_o, 0);
    check("rst_pre_pend", pend_o, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_enc", enc_o, 3);
    check("rst_pend", pend_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sat", sat_o, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      wr   = ($urandom_range(0, 3) == 0);
      step = CNT_W'($urandom_range(0, 15));
      clr  = ($urandom_range(0, 39) == 0);
      per  = PH_W'($urandom_range(0, 3));
      tick();
    end
    wr = 1'b0; clr = 1'b1; step = '0;
    tick();
    clr = 1'b0;
    wait_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
